tour_cmd_seq: RTL and testbench
===============================

# tour_cmd_seq

Converts the solved knight's-tour move list into a stream of robot motion commands. Sits directly downstream of the tour solver: it addresses the solver's move store through `mv_indx`, reads back the 8-bit one-hot `move`, and splits each knight move into two commands:
- a vertical leg;
- a horizontal leg.

Outside a tour it passes UART-originated commands straight through, so the command processor sees a single command source.

## Interface
- No parameters; all constants live in `tour_pkg`.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_tour` in 1: one-cycle pulse; solver `done` has already fired.
- `move` in 8: one-hot move at `mv_indx`, combinational from the solver.
- `mv_indx` out 5: index of the move being executed, 0..23.
- `cmd_UART` in 16: command from the UART wrapper.
- `cmd_rdy_UART` in 1: UART command valid.
- `clr_cmd_rdy` in 1: command processor has accepted the current `cmd`.
- `send_resp` in 1: command processor has finished executing the current command.
- `cmd` out 16: `{opcode[3:0], heading[7:0], squares[3:0]}`.
- `cmd_rdy` out 1: `cmd` valid.
- `resp` out 8: response byte for the UART.

## Operation
- Mode:
  - In IDLE: UART mode. `cmd` = `cmd_UART`, `cmd_rdy` = `cmd_rdy_UART`, `resp` = 8'hA5.
  - In all other states: tour mode, with outputs generated internally.
- Move decode (x+ = east, y+ = north):
  - bit0 = (−1,+2), bit1 = (+1,+2), bit2 = (−2,+1), bit3 = (−2,−1)
  - bit4 = (−1,−2), bit5 = (+1,−2), bit6 = (+2,−1), bit7 = (+2,+1)
- Headings: N = 8'h00, W = 8'h3F, S = 8'h7F, E = 8'hBF.
- Vertical leg: opcode 4'h2, heading N/S, squares = |dy|.
- Horizontal leg: opcode per Configuration, heading E/W, squares = |dx|.
- Non-one-hot `move`: both legs decode to heading N, squares 0. No error flag.
- State machine:
  - IDLE: on `start_tour`, clear `mv_indx` to 0 → VERT. `start_tour` is ignored in every other state.
  - VERT: `cmd_rdy` = 1, `cmd` = vertical leg. On `clr_cmd_rdy` → HOLD_V.
  - HOLD_V: `cmd_rdy` = 0. On `send_resp` → HORZ.
  - HORZ: `cmd_rdy` = 1, `cmd` = horizontal leg. On `clr_cmd_rdy` → HOLD_H.
  - HOLD_H: on `send_resp`:
    - if `mv_indx` == 23 → IDLE;
    - otherwise increment `mv_indx` → VERT.
- `resp` in tour mode:
  - 8'hA5 in HOLD_H when `mv_indx` == 23;
  - otherwise 8'h5A.
- Ignored inputs:
  - `send_resp` in VERT/HORZ;
  - `clr_cmd_rdy` in HOLD_V/HOLD_H;
  - `cmd_rdy_UART` in all tour states.
- Simultaneous `clr_cmd_rdy` and `send_resp` in VERT: only `clr_cmd_rdy` is honoured; `send_resp` is not latched.

## Timing
- Reset:
  - state IDLE, `mv_indx` = 0;
  - `cmd`/`cmd_rdy` follow `cmd_UART`/`cmd_rdy_UART` combinationally;
  - `resp` = 8'hA5.
- `mv_indx` is registered and `move` is combinational, so `cmd` is valid in the same cycle the state enters VERT/HORZ.
- `start_tour` at edge N: `cmd_rdy` = 1 from cycle N+1.
- `clr_cmd_rdy` at edge N: `cmd_rdy` = 0 from cycle N+1.
- `send_resp` at edge N in a HOLD state: next `cmd_rdy` = 1 from cycle N+1. Zero-bubble hand-off.
- Reset asserted mid-tour: immediate return to IDLE, `mv_indx` = 0, UART mode. There is no resume.
- `mv_indx` never exceeds 23 and does not wrap.

## Configuration
- `TOUR_CMD_FANFARE_EN` defined: horizontal-leg opcode = 4'h3 (move with fanfare); vertical leg stays 4'h2.
- Not defined: both legs use opcode 4'h2.

## Structure
- `tour_pkg`:
  - `state_t` enum: IDLE, VERT, HOLD_V, HORZ, HOLD_H;
  - heading constants;
  - opcodes `OP_MOVE` = 4'h2, `OP_MOVE_FF` = 4'h3;
  - `RESP_ACK` = 8'hA5, `RESP_POS` = 8'h5A;
  - `LAST_INDX` = 5'd23.
- One sub-module, `tour_move_decode`: purely combinational, `move[7:0]` → {vertical cmd, horizontal cmd}. It takes the fanfare opcode as an input so the macro is resolved in the parent.

## Test plan
- Reset with `cmd_UART` = 16'h2003 and `cmd_rdy_UART` = 1 → `cmd` = 16'h2003, `cmd_rdy` = 1, `resp` = 8'hA5, `mv_indx` = 0.
- `start_tour` with `move` = 8'h01, macro on:
  - `cmd` = 16'h2002 with `cmd_rdy` next cycle;
  - after `clr_cmd_rdy` then `send_resp`: `cmd` = 16'h33F1.
- `move` = 8'h40, macro off → vertical 16'h27F1, then horizontal 16'h2BF2.
- Full 24-move tour with a responder model:
  - `mv_indx` steps 0..23;
  - 48 commands are issued;
  - `resp` = 8'h5A until the final HOLD_H, where it is 8'hA5;
  - the block returns to IDLE.
- `start_tour` and `cmd_rdy_UART` pulses mid-tour → ignored. `send_resp` in VERT → no state change.
- `rst_n` low during HOLD_V at `mv_indx` = 7 → IDLE, `mv_indx` = 0, UART passthrough restored.

Source files
------------

// File: rtl/tour_cmd_seq_pkg.sv
// Shared types and constants for the knight's-tour command sequencer.
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    HOLD_V,
    HORZ,
    HOLD_H
  } state_t;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_MOVE_FF = 4'h3;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_POS = 8'h5A;

  localparam logic [4:0] LAST_INDX = 5'd23;

  function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                         input logic [7:0] hdg,
                                         input logic [3:0] sq);
    return {op, hdg, sq};
  endfunction

endpackage

// File: rtl/tour_cmd_seq_if.sv
// Command-processor handshake between the sequencer (master) and its consumer (slave).
interface tour_cmd_seq_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;
  logic        clr_cmd_rdy;
  logic        send_resp;

  modport master (output cmd, output cmd_rdy, output resp,
                  input  clr_cmd_rdy, input send_resp);
  modport slave  (input  cmd, input cmd_rdy, input resp,
                  output clr_cmd_rdy, output send_resp);
endinterface

// File: rtl/tour_cmd_seq_move_decode.sv
// Combinational split of a one-hot knight move into vertical and horizontal leg commands.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  i_move,
  input  logic [3:0]  i_op_horz,
  output logic [15:0] o_cmd_vert,
  output logic [15:0] o_cmd_horz
);

  logic [7:0] w_hdg_v;
  logic [3:0] w_sq_v;
  logic [7:0] w_hdg_h;
  logic [3:0] w_sq_h;

  // Anything not exactly one-hot falls through to a zero-length north move.
  always_comb begin
    w_hdg_v = HDG_N;
    w_sq_v  = '0;
    w_hdg_h = HDG_N;
    w_sq_h  = '0;
    case (i_move)
      8'h01: begin w_hdg_v = HDG_N; w_sq_v = 4'd2; w_hdg_h = HDG_W; w_sq_h = 4'd1; end
      8'h02: begin w_hdg_v = HDG_N; w_sq_v = 4'd2; w_hdg_h = HDG_E; w_sq_h = 4'd1; end
      8'h04: begin w_hdg_v = HDG_N; w_sq_v = 4'd1; w_hdg_h = HDG_W; w_sq_h = 4'd2; end
      8'h08: begin w_hdg_v = HDG_S; w_sq_v = 4'd1; w_hdg_h = HDG_W; w_sq_h = 4'd2; end
      8'h10: begin w_hdg_v = HDG_S; w_sq_v = 4'd2; w_hdg_h = HDG_W; w_sq_h = 4'd1; end
      8'h20: begin w_hdg_v = HDG_S; w_sq_v = 4'd2; w_hdg_h = HDG_E; w_sq_h = 4'd1; end
      8'h40: begin w_hdg_v = HDG_S; w_sq_v = 4'd1; w_hdg_h = HDG_E; w_sq_h = 4'd2; end
      8'h80: begin w_hdg_v = HDG_N; w_sq_v = 4'd1; w_hdg_h = HDG_E; w_sq_h = 4'd2; end
      default: ;
    endcase
  end

  assign o_cmd_vert = mk_cmd(OP_MOVE, w_hdg_v, w_sq_v);
  assign o_cmd_horz = mk_cmd(i_op_horz, w_hdg_h, w_sq_h);

endmodule

// File: rtl/tour_cmd_seq.sv
// Knight's-tour move list to robot command sequencer with UART passthrough in IDLE.
// Optional TOUR_CMD_FANFARE_EN: horizontal legs use the fanfare move opcode.
module tour_cmd_seq
  import tour_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  tour_cmd_seq_if.master cp
);

`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] OP_HORZ = OP_MOVE_FF;
`else
  localparam logic [3:0] OP_HORZ = OP_MOVE;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_mv_indx;
  logic [4:0]  w_mv_indx_nxt;
  logic [15:0] w_cmd_vert;
  logic [15:0] w_cmd_horz;

  tour_move_decode u_decode (
    .i_move     (move),
    .i_op_horz  (OP_HORZ),
    .o_cmd_vert (w_cmd_vert),
    .o_cmd_horz (w_cmd_horz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mv_indx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mv_indx <= w_mv_indx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mv_indx_nxt = r_mv_indx;
    cp.cmd        = cmd_UART;
    cp.cmd_rdy    = cmd_rdy_UART;
    cp.resp       = RESP_ACK;
    case (r_state)
      IDLE: begin
        if (start_tour) begin
          w_mv_indx_nxt = '0;
          w_state_nxt   = VERT;
        end
      end
      VERT: begin
        cp.cmd     = w_cmd_vert;
        cp.cmd_rdy = 1'b1;
        cp.resp    = RESP_POS;
        if (cp.clr_cmd_rdy) w_state_nxt = HOLD_V;
      end
      HOLD_V: begin
        cp.cmd     = w_cmd_vert;
        cp.cmd_rdy = 1'b0;
        cp.resp    = RESP_POS;
        if (cp.send_resp) w_state_nxt = HORZ;
      end
      HORZ: begin
        cp.cmd     = w_cmd_horz;
        cp.cmd_rdy = 1'b1;
        cp.resp    = RESP_POS;
        if (cp.clr_cmd_rdy) w_state_nxt = HOLD_H;
      end
      HOLD_H: begin
        cp.cmd     = w_cmd_horz;
        cp.cmd_rdy = 1'b0;
        cp.resp    = (r_mv_indx == LAST_INDX) ? RESP_ACK : RESP_POS;
        if (cp.send_resp) begin
          if (r_mv_indx == LAST_INDX) begin
            w_state_nxt = IDLE;
          end else begin
            w_mv_indx_nxt = r_mv_indx + 5'd1;
            w_state_nxt   = VERT;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mv_indx = r_mv_indx;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed self-checking bench for tour_cmd_seq: vector table plus multi-cycle sequences.
module tb_tour_cmd_seq;

`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] HOP = 4'h3;
`else
  localparam logic [3:0] HOP = 4'h2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [7:0]  move_drv;
  logic        use_tab;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic [7:0]  mv_tab [24];

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned n_cmds  = 0;

  tour_cmd_seq_if u_if ();

  tour_cmd_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .cp           (u_if.master)
  );

  always #5 clk = ~clk;

  always_comb move = use_tab ? mv_tab[mv_indx] : move_drv;

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] v;
    logic [11:0] h;   // heading + squares; opcode added per build
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_clr();
    u_if.clr_cmd_rdy = 1'b1; tick(); u_if.clr_cmd_rdy = 1'b0; #1;
  endtask

  task automatic pulse_send();
    u_if.send_resp = 1'b1; tick(); u_if.send_resp = 1'b0; #1;
  endtask

  task automatic pulse_start();
    start_tour = 1'b1; tick(); start_tour = 1'b0; #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #3; rst_n = 1'b1; #1;
  endtask

  // Reference decode from the (dx,dy) displacement of each move bit.
  function automatic void model(input logic [7:0] m, output logic [15:0] v, output logic [15:0] h);
    int dx, dy;
    dx = 0; dy = 0;
    case (m)
      8'h01: begin dx = -1; dy =  2; end
      8'h02: begin dx =  1; dy =  2; end
      8'h04: begin dx = -2; dy =  1; end
      8'h08: begin dx = -2; dy = -1; end
      8'h10: begin dx = -1; dy = -2; end
      8'h20: begin dx =  1; dy = -2; end
      8'h40: begin dx =  2; dy = -1; end
      8'h80: begin dx =  2; dy =  1; end
      default: ;
    endcase
    v = {4'h2, (dy < 0) ? 8'h7F : 8'h00, 4'((dy < 0) ? -dy : dy)};
    h = {HOP, (dx > 0) ? 8'hBF : ((dx < 0) ? 8'h3F : 8'h00), 4'((dx < 0) ? -dx : dx)};
  endfunction

  initial begin
    logic [15:0] ev, eh;

    vecs[0] = '{8'h01, 16'h2002, 12'h3F1};
    vecs[1] = '{8'h02, 16'h2002, 12'hBF1};
    vecs[2] = '{8'h04, 16'h2001, 12'h3F2};
    vecs[3] = '{8'h08, 16'h27F1, 12'h3F2};
    vecs[4] = '{8'h10, 16'h27F2, 12'h3F1};
    vecs[5] = '{8'h20, 16'h27F2, 12'hBF1};
    vecs[6] = '{8'h40, 16'h27F1, 12'hBF2};
    vecs[7] = '{8'h80, 16'h2001, 12'hBF2};
    vecs[8] = '{8'h03, 16'h2000, 12'h000};
    vecs[9] = '{8'h00, 16'h2000, 12'h000};
    for (int i = 0; i < 24; i++) mv_tab[i] = 8'h01 << ((i * 3) % 8);

    start_tour = 1'b0; u_if.clr_cmd_rdy = 1'b0; u_if.send_resp = 1'b0;
    use_tab = 1'b0; move_drv = 8'h00;
    cmd_UART = 16'h2003; cmd_rdy_UART = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("reset_cmd", u_if.cmd, 16'h2003);
    chk("reset_cmd_rdy", u_if.cmd_rdy, 1'b1);
    chk("reset_resp", u_if.resp, 8'hA5);
    chk("reset_mv_indx", mv_indx, 5'd0);
    #12; rst_n = 1'b1;
    tick();
    cmd_rdy_UART = 1'b0; #1;
    chk("idle_rdy_follow", u_if.cmd_rdy, 1'b0);

    // Table of single moves: vertical leg, hold, horizontal leg, then abort by reset.
    for (int unsigned i = 0; i < 10; i++) begin
      move_drv = vecs[i].mv;
      pulse_start();
      chk($sformatf("vec%0d_vert_rdy", i), u_if.cmd_rdy, 1'b1);
      chk($sformatf("vec%0d_vert_cmd", i), u_if.cmd, vecs[i].v);
      pulse_clr();
      chk($sformatf("vec%0d_holdv_rdy", i), u_if.cmd_rdy, 1'b0);
      pulse_send();
      chk($sformatf("vec%0d_horz_rdy", i), u_if.cmd_rdy, 1'b1);
      chk($sformatf("vec%0d_horz_cmd", i), u_if.cmd, {HOP, vecs[i].h});
      do_reset();
      chk($sformatf("vec%0d_abort_cmd", i), u_if.cmd, cmd_UART);
    end

    // clr_cmd_rdy and send_resp together in VERT: send_resp must not be latched.
    move_drv = 8'h40;
    pulse_start();
    u_if.clr_cmd_rdy = 1'b1; u_if.send_resp = 1'b1; tick();
    u_if.clr_cmd_rdy = 1'b0; u_if.send_resp = 1'b0; #1;
    chk("simul_holdv_rdy", u_if.cmd_rdy, 1'b0);
    tick();
    chk("simul_no_latch_rdy", u_if.cmd_rdy, 1'b0);
    pulse_send();
    chk("simul_horz_cmd", u_if.cmd, {HOP, 12'hBF2});
    do_reset();

    // Full 24-move tour with a responder, plus ignored-input checks at move 5.
    use_tab = 1'b1; cmd_UART = 16'h1234; cmd_rdy_UART = 1'b0;
    pulse_start();
    for (int unsigned k = 0; k < 24; k++) begin
      model(mv_tab[k], ev, eh);
      chk($sformatf("tour%0d_indx", k), mv_indx, 5'(k));
      chk($sformatf("tour%0d_vert", k), {u_if.cmd_rdy, u_if.cmd}, {1'b1, ev});
      chk($sformatf("tour%0d_resp_v", k), u_if.resp, 8'h5A);
      if (u_if.cmd_rdy === 1'b1) n_cmds++;
      if (k == 5) begin
        start_tour = 1'b1; cmd_rdy_UART = 1'b1; u_if.send_resp = 1'b1; tick();
        start_tour = 1'b0; cmd_rdy_UART = 1'b0; u_if.send_resp = 1'b0; #1;
        chk("ignored_indx", mv_indx, 5'd5);
        chk("ignored_vert", {u_if.cmd_rdy, u_if.cmd}, {1'b1, ev});
      end
      pulse_clr();
      chk($sformatf("tour%0d_holdv", k), u_if.cmd_rdy, 1'b0);
      pulse_send();
      chk($sformatf("tour%0d_horz", k), {u_if.cmd_rdy, u_if.cmd}, {1'b1, eh});
      if (u_if.cmd_rdy === 1'b1) n_cmds++;
      pulse_clr();
      chk($sformatf("tour%0d_resp_h", k), u_if.resp, (k == 23) ? 8'hA5 : 8'h5A);
      pulse_send();
    end
    chk("tour_cmd_count", n_cmds, 48);
    chk("tour_end_cmd", u_if.cmd, 16'h1234);
    chk("tour_end_rdy", u_if.cmd_rdy, 1'b0);
    chk("tour_end_resp", u_if.resp, 8'hA5);
    cmd_rdy_UART = 1'b1; #1;
    chk("tour_end_uart_rdy", u_if.cmd_rdy, 1'b1);
    cmd_rdy_UART = 1'b0;

    // Reset while in HOLD_V at move 7.
    pulse_start();
    for (int unsigned k = 0; k < 7; k++) begin
      pulse_clr(); pulse_send(); pulse_clr(); pulse_send();
    end
    pulse_clr();
    chk("rst7_indx_pre", mv_indx, 5'd7);
    chk("rst7_holdv", u_if.cmd_rdy, 1'b0);
    cmd_rdy_UART = 1'b1;
    rst_n = 1'b0; #1;
    chk("rst7_indx", mv_indx, 5'd0);
    chk("rst7_cmd", u_if.cmd, 16'h1234);
    chk("rst7_rdy", u_if.cmd_rdy, 1'b1);
    chk("rst7_resp", u_if.resp, 8'hA5);
    #3; rst_n = 1'b1;
    tick();
    chk("rst7_stay_idle", u_if.cmd, 16'h1234);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
